// File: rtl/router_dst_port_pkg.sv
// Shared types and constants for the router destination output port.
package router_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned DEF_DEPTH   = 16;
    localparam int unsigned DEF_TIMEOUT = 30;

    localparam int unsigned LEN_MSB = 7;
    localparam int unsigned LEN_LSB = 2;

    // Payload length plus the parity byte needs one bit more than the length field.
    localparam int unsigned PKT_CNT_W = LEN_MSB - LEN_LSB + 2;

    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic logic [PKT_CNT_W-1:0] hdr_pkt_len(input logic [DATA_W-1:0] hdr_byte);
        return PKT_CNT_W'(hdr_byte[LEN_MSB:LEN_LSB]) + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_dst_port_if.sv
// Core/destination-side signal bundle of one router output port.
interface router_dst_port_if;
    import router_pkg::*;

    logic              write_enb;
    logic [DATA_W-1:0] data_in;
    logic              lfd;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              full;
    logic              busy;
    logic              soft_reset;

    modport master (
        output write_enb, data_in, lfd, read_enb,
        input  data_out, valid_out, full, busy, soft_reset
    );

    modport slave (
        input  write_enb, data_in, lfd, read_enb,
        output data_out, valid_out, full, busy, soft_reset
    );

endinterface

// File: rtl/router_dst_timer.sv
// Idle timer and soft_reset pulse generator of the output port.
// Only present when ROUTER_DST_TIMEOUT_EN is defined.
`ifdef ROUTER_DST_TIMEOUT_EN
module router_dst_timer
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic valid_i,
    input  logic read_i,
    output logic flush_o,
    output logic soft_reset_o
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          soft_reset_q, soft_reset_d;

    // A read is accepted whenever data is waiting, so valid && read clears the timer.
    assign flush_o      = valid_i && !read_i && (timer_q == LAST);
    assign soft_reset_o = soft_reset_q;

    // Next-state for idle counter and flush pulse.
    always_comb begin
        timer_d      = timer_q;
        soft_reset_d = flush_o;
        if (!valid_i) begin
            timer_d = '0;
        end else if (read_i) begin
            timer_d = '0;
        end else if (timer_q == LAST) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Timer and pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q      <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            soft_reset_q <= soft_reset_d;
        end
    end

endmodule
`endif

// File: rtl/router_dst_port.sv
// Router output port: 9-bit FIFO with packet tracking and optional idle flush.
// Define ROUTER_DST_TIMEOUT_EN to build the idle timer; otherwise soft_reset is tied low.
module router_dst_port
    import router_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    router_dst_port_if.slave dst
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 2)) begin : g_bad_param
        $error("router_dst_port: DEPTH must be a power of two >= 4 and TIMEOUT >= 2");
    end

    fifo_entry_t          mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic        valid_s;
    logic        full_s;
    logic        wr_ok_s;
    logic        rd_ok_s;
    logic        mem_we_s;
    logic        flush_s;
    logic        soft_reset_s;
    fifo_entry_t rd_entry_s;
    fifo_entry_t wr_entry_s;

    // Status is decoded from registered pointers only, never from this cycle's inputs.
    assign valid_s    = (wr_ptr_q != rd_ptr_q);
    assign full_s     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign wr_ok_s    = dst.write_enb && !full_s;
    assign rd_ok_s    = dst.read_enb && valid_s;
    assign rd_entry_s = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_entry_s = '{hdr: dst.lfd, data: dst.data_in};

`ifdef ROUTER_DST_TIMEOUT_EN
    router_dst_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock        (clock),
        .reset        (reset),
        .valid_i      (valid_s),
        .read_i       (dst.read_enb),
        .flush_o      (flush_s),
        .soft_reset_o (soft_reset_s)
    );
`else
    assign flush_s      = 1'b0;
    assign soft_reset_s = 1'b0;
`endif

    // Next-state for pointers, read data and packet counter; a flush overrides everything.
    always_comb begin
        mem_we_s   = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (flush_s) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            data_out_d = '0;
            pkt_cnt_d  = '0;
        end else begin
            if (wr_ok_s) begin
                mem_we_s = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                mem_we_s = 1'b0;
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                data_out_d = rd_entry_s.data;
                if (rd_entry_s.hdr) begin
                    pkt_cnt_d = hdr_pkt_len(rd_entry_s.data);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
                end else begin
                    pkt_cnt_d = pkt_cnt_q;
                end
            end else begin
                rd_ptr_d   = rd_ptr_q;
                data_out_d = data_out_q;
                pkt_cnt_d  = pkt_cnt_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // Storage array; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_s;
        end
    end

    assign dst.data_out   = data_out_q;
    assign dst.valid_out  = valid_s;
    assign dst.full       = full_s;
    assign dst.busy       = full_s;
    assign dst.soft_reset = soft_reset_s;

endmodule

// File: tb/tb_router_dst_port.sv
// Directed self-checking bench for router_dst_port (DEPTH=16, TIMEOUT=30).
module tb_router_dst_port;
    import router_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    router_dst_port_if bus();

    router_dst_port #(
        .DEPTH   (16),
        .TIMEOUT (30)
    ) dut (
        .clock (clock),
        .reset (reset),
        .dst   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] d, input logic l, input logic re);
        bus.write_enb = we;
        bus.data_in   = d;
        bus.lfd       = l;
        bus.read_enb  = re;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(bus.data_out), 32'h0);
        check({tag, "_valid"}, 32'(bus.valid_out), 32'h0);
        check({tag, "_full"},  32'(bus.full), 32'h0);
        check({tag, "_busy"},  32'(bus.busy), 32'h0);
        check({tag, "_soft"},  32'(bus.soft_reset), 32'h0);
        check({tag, "_pkt"},   32'(dut.pkt_cnt_q), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pkt1 [5];
        logic [7:0] pkt2 [3];
        logic [7:0] model [$];
        logic [7:0] w;
        logic [7:0] e;

        pkt1 = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
        pkt2 = '{8'h04, 8'hC1, 8'h3A};

        // Reset state
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("rst");
        reset = 1'b0;

        // Header 0x0C (len 3) + 3 payload + parity
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pkt1[i], (i == 0), 1'b0);
            tick();
            if (i == 0) check("p1_valid_first", 32'(bus.valid_out), 32'h1);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            tick();
            check("p1_data", 32'(bus.data_out), 32'(pkt1[i]));
            if (i == 0) check("p1_pkt_load", 32'(dut.pkt_cnt_q), 32'h4);
        end
        check("p1_valid_end", 32'(bus.valid_out), 32'h0);
        check("p1_pkt_end", 32'(dut.pkt_cnt_q), 32'h0);
        tick();
        check("p1_empty_read_hold", 32'(bus.data_out), 32'h5E);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill past full: 17 writes, 17th dropped
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
            if (i == 15) check("fill_full_15", 32'(bus.full), 32'h0);
            if (i == 16) check("fill_full_16", 32'(bus.full), 32'h1);
            if (i == 16) check("fill_busy_16", 32'(bus.busy), 32'h1);
            if (i == 17) check("fill_full_17", 32'(bus.full), 32'h1);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            tick();
            check("fill_data", 32'(bus.data_out), 32'(i));
            if (i == 1) check("fill_full_after_rd", 32'(bus.full), 32'h0);
        end
        check("fill_valid_end", 32'(bus.valid_out), 32'h0);

        // Simultaneous read/write across pointer wrap
        for (int i = 0; i < 5; i++) begin
            w = 8'h40 + 8'(i);
            drive(1'b1, w, 1'b0, 1'b0);
            model.push_back(w);
            tick();
        end
        for (int c = 0; c < 40; c++) begin
            w = 8'(c * 7 + 3);
            drive(1'b1, w, 1'b0, 1'b1);
            e = model.pop_front();
            model.push_back(w);
            tick();
            check("wrap_data", 32'(bus.data_out), 32'(e));
            check("wrap_valid", 32'(bus.valid_out), 32'h1);
            check("wrap_full", 32'(bus.full), 32'h0);
        end
        while (model.size() > 0) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            e = model.pop_front();
            tick();
            check("wrap_drain", 32'(bus.data_out), 32'(e));
        end
        check("wrap_valid_end", 32'(bus.valid_out), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef ROUTER_DST_TIMEOUT_EN
        // Timeout flush with a write on the flush cycle
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        check("to_valid", 32'(bus.valid_out), 32'h1);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        for (int k = 2; k <= 30; k++) begin
            tick();
            check("to_no_soft", 32'(bus.soft_reset), 32'h0);
            if (k == 30) begin
                check("to_valid_c30", 32'(bus.valid_out), 32'h1);
                drive(1'b1, 8'h99, 1'b0, 1'b0);
            end else begin
                drive(1'b0, 8'h00, 1'b0, 1'b0);
            end
        end
        tick();
        check("to_soft_pulse", 32'(bus.soft_reset), 32'h1);
        check("to_valid_flush", 32'(bus.valid_out), 32'h0);
        check("to_data_flush", 32'(bus.data_out), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("to_soft_once", 32'(bus.soft_reset), 32'h0);
        check("to_write_dropped", 32'(bus.valid_out), 32'h0);

        // Read on idle cycle 29 restarts the timer
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        for (int k = 2; k <= 29; k++) begin
            tick();
            if (k == 29) drive(1'b0, 8'h00, 1'b0, 1'b1);
            else         drive(1'b0, 8'h00, 1'b0, 1'b0);
        end
        tick();
        check("rs_read_data", 32'(bus.data_out), 32'h11);
        check("rs_no_soft", 32'(bus.soft_reset), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int j = 1; j <= 29; j++) begin
            tick();
            check("rs_quiet", 32'(bus.soft_reset), 32'h0);
        end
        tick();
        check("rs_late_soft", 32'(bus.soft_reset), 32'h1);
        check("rs_late_valid", 32'(bus.valid_out), 32'h0);
        tick();
        check("rs_late_soft_once", 32'(bus.soft_reset), 32'h0);
`else
        // No timer: data waits indefinitely
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int j = 0; j < 100; j++) begin
            tick();
            check("nt_no_soft", 32'(bus.soft_reset), 32'h0);
        end
        check("nt_valid", 32'(bus.valid_out), 32'h1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("nt_data0", 32'(bus.data_out), 32'h11);
        tick();
        check("nt_data1", 32'(bus.data_out), 32'h22);
        check("nt_valid_end", 32'(bus.valid_out), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
`endif

        // Reset mid-packet after 3 of 5 reads
        pkt1 = '{8'h0C, 8'hB1, 8'hB2, 8'hB3, 8'h4D};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pkt1[i], (i == 0), 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            tick();
            check("mid_data", 32'(bus.data_out), 32'(pkt1[i]));
        end
        check("mid_pkt", 32'(dut.pkt_cnt_q), 32'h2);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_all_zero("mid_rst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pkt2[i], (i == 0), 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            tick();
            check("post_data", 32'(bus.data_out), 32'(pkt2[i]));
            if (i == 0) check("post_pkt_load", 32'(dut.pkt_cnt_q), 32'h2);
        end
        check("post_valid_end", 32'(bus.valid_out), 32'h0);
        check("post_pkt_end", 32'(dut.pkt_cnt_q), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
